// File: rtl/if_loader_pkg.sv
// Shared types and constants for the IF program loader.
// State encodings, instruction width and the default end-of-program word.
package if_loader_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

endpackage

// File: rtl/if_prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader is the slave; the byte source / memory side is the master.
interface if_prog_loader_if;
  import if_loader_pkg::*;

  logic [7:0]         i_byte;
  logic               i_byte_valid;
  logic               o_byte_ready;
  logic               o_write_en;
  logic [INSTR_W-1:0] o_data;
  logic [31:0]        o_addr_wr;

  modport master (
    output i_byte,
    output i_byte_valid,
    input  o_byte_ready,
    input  o_write_en,
    input  o_data,
    input  o_addr_wr
  );

  modport slave (
    input  i_byte,
    input  i_byte_valid,
    output o_byte_ready,
    output o_write_en,
    output o_data,
    output o_addr_wr
  );

endinterface

// File: rtl/word_assembler.sv
// Packs accepted bytes big-endian into a 32-bit word.
// word_valid pulses combinationally on the 4th accepted byte.
module word_assembler
  import if_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [7:0]         byte_in,
  input  logic               byte_en,
  output logic [INSTR_W-1:0] word,
  output logic               word_valid
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  byte_idx_q, byte_idx_d;

  always_comb begin
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    if (clr) begin
      shift_d    = '0;
      byte_idx_d = '0;
    end else if (byte_en) begin
      shift_d    = {shift_q[15:0], byte_in};
      byte_idx_d = byte_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  assign word       = {shift_q, byte_in};
  assign word_valid = byte_en && (byte_idx_q == 2'd3);

endmodule

// File: rtl/if_prog_loader.sv
// Loads a byte-streamed program into IF instruction memory,
// then releases the pipeline once the HALT word has been stored.
module if_prog_loader
  import if_loader_pkg::*;
#(
  parameter int                 MEM_DEPTH = 256,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  if_prog_loader_if.slave            bus,
  output logic                       o_read_en,
  output logic                       o_cpu_en,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_overflow,
  output logic [$clog2(MEM_DEPTH):0] o_word_count
);

  localparam int CW = $clog2(MEM_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(MEM_DEPTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      wc_q, wc_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic [31:0]        addr_q, addr_d;
  logic               clr;
  logic               accept;
  logic [INSTR_W-1:0] word;
  logic               word_valid;

  assign accept = bus.i_byte_valid && (state_q == ST_RECV);

  word_assembler u_asm (
    .clk        (i_clk),
    .rst_n      (i_reset),
    .clr        (clr),
    .byte_in    (bus.i_byte),
    .byte_en    (accept),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    data_d  = data_q;
    addr_d  = addr_q;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_d = ST_RECV;
          wc_d    = '0;
          clr     = 1'b1;
        end
      end
      ST_RECV: begin
        if (word_valid) begin
          state_d = ST_WRITE;
          data_d  = word;
          addr_d  = 32'({wc_q, 2'b00});
        end
      end
      ST_WRITE: begin
        wc_d = wc_q + 1'b1;
        // HALT in the last slot still counts as a clean finish
        if (data_q == HALT_WORD)   state_d = ST_DONE;
        else if (wc_d == DEPTH_C) state_d = ST_ERROR;
        else                      state_d = ST_RECV;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      wc_q    <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.o_byte_ready = (state_q == ST_RECV);
  assign bus.o_write_en   = (state_q == ST_WRITE);
  assign bus.o_data       = data_q;
  assign bus.o_addr_wr    = addr_q;
  assign o_busy           = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign o_done           = (state_q == ST_DONE);
  assign o_overflow       = (state_q == ST_ERROR);
  assign o_read_en        = (state_q == ST_DONE);
  assign o_cpu_en         = (state_q == ST_DONE);
  assign o_word_count     = wc_q;

endmodule

// File: tb/tb_if_prog_loader.sv
// Scoreboard bench for if_prog_loader (depth 256 and depth 4).
module tb_if_prog_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start4;

  always #5 clk = ~clk;

  if_prog_loader_if bif ();
  if_prog_loader_if b4 ();

  logic       rd0, cpu0, busy0, done0, ovf0;
  logic [8:0] wc0;
  logic       rd4, cpu4, busy4, done4, ovf4;
  logic [2:0] wc4;

  if_prog_loader #(.MEM_DEPTH(256)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_start      (start0),
    .bus          (bif),
    .o_read_en    (rd0),
    .o_cpu_en     (cpu0),
    .o_busy       (busy0),
    .o_done       (done0),
    .o_overflow   (ovf0),
    .o_word_count (wc0)
  );

  if_prog_loader #(.MEM_DEPTH(4)) dut4 (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_start      (start4),
    .bus          (b4),
    .o_read_en    (rd4),
    .o_cpu_en     (cpu4),
    .o_busy       (busy4),
    .o_done       (done4),
    .o_overflow   (ovf4),
    .o_word_count (wc4)
  );

  int checks = 0;
  int failures = 0;
  logic [63:0] q0[$];
  logic [63:0] q4[$];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // scoreboard monitors: every write strobe must match the next expected entry
  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    if (bif.o_write_en === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write0 got=%h@%h want=none",
                 bif.o_data, bif.o_addr_wr);
      end else begin
        e = q0.pop_front();
        if ({bif.o_addr_wr, bif.o_data} !== e) begin
          failures++;
          $display("FAIL write0 got=%h@%h want=%h@%h",
                   bif.o_data, bif.o_addr_wr, e[31:0], e[63:32]);
        end
      end
    end
  end

  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    if (b4.o_write_en === 1'b1) begin
      checks++;
      if (q4.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write4 got=%h@%h want=none",
                 b4.o_data, b4.o_addr_wr);
      end else begin
        e = q4.pop_front();
        if ({b4.o_addr_wr, b4.o_data} !== e) begin
          failures++;
          $display("FAIL write4 got=%h@%h want=%h@%h",
                   b4.o_data, b4.o_addr_wr, e[31:0], e[63:32]);
        end
      end
    end
  end

  task automatic put_byte(input int d, input logic [7:0] b);
    logic r;
    int t;
    t = 0;
    if (d == 0) begin bif.i_byte = b; bif.i_byte_valid = 1'b1; end
    else        begin b4.i_byte = b;  b4.i_byte_valid = 1'b1; end
    forever begin
      @(negedge clk);
      r = (d == 0) ? bif.o_byte_ready : b4.o_byte_ready;
      @(posedge clk); #1;
      if (r) break;
      t++;
      if (t > 20) begin
        checks++;
        failures++;
        $display("FAIL byte_timeout got=stalled want=accepted");
        break;
      end
    end
    bif.i_byte_valid = 1'b0;
    b4.i_byte_valid  = 1'b0;
  endtask

  // called right after the 4th byte was accepted
  task automatic finish_write(input int d);
    @(negedge clk);
    chk("wr_latency", (d == 0) ? bif.o_write_en : b4.o_write_en, 1);
    chk("ready_in_write", (d == 0) ? bif.o_byte_ready : b4.o_byte_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input int d, input logic [31:0] w,
                           input logic [31:0] a);
    if (d == 0) q0.push_back({a, w});
    else        q4.push_back({a, w});
    for (int i = 3; i >= 0; i--) put_byte(d, w[i*8 +: 8]);
    finish_write(d);
  endtask

  task automatic pulse_start(input int d);
    if (d == 0) start0 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic idle_valid(input int d, input string name);
    for (int i = 0; i < 3; i++) begin
      if (d == 0) begin bif.i_byte = 8'h99; bif.i_byte_valid = 1'b1; end
      else        begin b4.i_byte = 8'h99;  b4.i_byte_valid = 1'b1; end
      @(negedge clk);
      chk(name, (d == 0) ? bif.o_byte_ready : b4.o_byte_ready, 0);
      @(posedge clk); #1;
    end
    bif.i_byte_valid = 1'b0;
    b4.i_byte_valid  = 1'b0;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_outs"},
        {26'd0, bif.o_byte_ready, bif.o_write_en, rd0, cpu0, busy0, done0, ovf0}, 0);
    chk({name, "_wc"}, 32'(wc0), 0);
    chk({name, "_data"}, bif.o_data, 0);
    chk({name, "_addr"}, bif.o_addr_wr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0;
    start4 = 1'b0;
    bif.i_byte = 8'h00; bif.i_byte_valid = 1'b0;
    b4.i_byte  = 8'h00; b4.i_byte_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("reset");
    chk("reset_dut4", {26'd0, b4.o_write_en, busy4, done4, ovf4, cpu4, rd4} | 32'(wc4), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // bytes offered in IDLE are ignored
    idle_valid(0, "idle_ready");

    // basic load: program word then HALT
    pulse_start(0);
    @(negedge clk);
    chk("busy_recv", busy0, 1);
    chk("cpu_frozen", cpu0, 0);
    @(posedge clk); #1;
    send_word(0, 32'h2008_0005, 32'd0);
    send_word(0, 32'hFFFF_FFFF, 32'd4);
    @(negedge clk);
    chk("t1_done", done0, 1);
    chk("t1_wc", 32'(wc0), 2);
    chk("t1_cpu_en", cpu0, 1);
    chk("t1_read_en", rd0, 1);
    chk("t1_busy", busy0, 0);
    @(posedge clk); #1;

    // DONE ignores stray bytes
    idle_valid(0, "done_ready");
    @(negedge clk);
    chk("done_hold", done0, 1);
    chk("done_wc_hold", 32'(wc0), 2);
    @(posedge clk); #1;

    // start together with a valid byte in DONE: byte not taken
    start0 = 1'b1;
    bif.i_byte = 8'hAA;
    bif.i_byte_valid = 1'b1;
    @(negedge clk);
    chk("restart_ready", bif.o_byte_ready, 0);
    chk("restart_cpu_before", cpu0, 1);
    @(posedge clk); #1;
    start0 = 1'b0;
    bif.i_byte_valid = 1'b0;
    @(negedge clk);
    chk("restart_cpu_after", cpu0, 0);
    chk("restart_wc", 32'(wc0), 0);
    chk("restart_busy", busy0, 1);
    @(posedge clk); #1;
    send_word(0, 32'h1122_3344, 32'd0);

    // start mid-RECV is ignored
    q0.push_back({32'd4, 32'h5566_7788});
    put_byte(0, 8'h55);
    put_byte(0, 8'h66);
    pulse_start(0);
    put_byte(0, 8'h77);
    put_byte(0, 8'h88);
    finish_write(0);
    @(negedge clk);
    chk("midstart_busy", busy0, 1);
    chk("midstart_wc", 32'(wc0), 2);
    @(posedge clk); #1;

    // reset after 2 bytes discards the partial word
    put_byte(0, 8'hC0);
    put_byte(0, 8'hC1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse_start(0);
    send_word(0, 32'hDEAD_BEEF, 32'd0);
    send_word(0, 32'hFFFF_FFFF, 32'd4);
    @(negedge clk);
    chk("reload_done", done0, 1);
    chk("reload_wc", 32'(wc0), 2);
    @(posedge clk); #1;

    // depth-4 memory filled without HALT
    pulse_start(4);
    send_word(4, 32'h0102_0304, 32'd0);
    send_word(4, 32'h0A0B_0C0D, 32'd4);
    send_word(4, 32'h1111_1111, 32'd8);
    send_word(4, 32'h1234_5678, 32'd12);
    @(negedge clk);
    chk("ovf_flag", ovf4, 1);
    chk("ovf_done", done4, 0);
    chk("ovf_ready", b4.o_byte_ready, 0);
    chk("ovf_cpu", cpu4, 0);
    chk("ovf_busy", busy4, 0);
    chk("ovf_wc", 32'(wc4), 4);
    @(posedge clk); #1;
    idle_valid(4, "err_ready");

    // HALT in the last slot finishes as DONE
    pulse_start(4);
    @(negedge clk);
    chk("err_restart_ovf", ovf4, 0);
    @(posedge clk); #1;
    send_word(4, 32'hAAAA_0001, 32'd0);
    send_word(4, 32'hAAAA_0002, 32'd4);
    send_word(4, 32'hAAAA_0003, 32'd8);
    send_word(4, 32'hFFFF_FFFF, 32'd12);
    @(negedge clk);
    chk("last_halt_done", done4, 1);
    chk("last_halt_ovf", ovf4, 0);
    chk("last_halt_wc", 32'(wc4), 4);
    chk("last_halt_cpu", cpu4, 1);

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
